// File: rtl/adder_axi_sequencer.sv
// adder_axi_sequencer
//   AXI4-Lite master that runs one complete add on the adder slave per
//   request. It writes operand A to BASE_ADDR+0 and operand B to +4, then
//   reads the sum from +8 and the overflow flag from +12 (bit 0).
//   If a response is not OKAY, or a phase stalls for TIMEOUT_CYCLES
//   cycles, the operation is abandoned. It still finishes with done, and
//   err is set.
//
// Ports
//   m1_axi_aclk, m1_axi_aresetn : clock, synchronous active-low reset
//   start, op_a, op_b           : request pulse and operands (sampled in IDLE)
//   busy, done                  : in-flight flag, one-cycle completion pulse
//   sum, overflow               : results of the last successful read-back
//   err, err_phase              : abort flag and phase code (1..4, 0 = none)
//   m1_axi_aw*/w*/b*/ar*/r*     : AXI4-Lite master channels
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for start
// S_WR_A   | write op_a to +0 (AW/W in any order, then B)
// S_WR_B   | write op_b to +4
// S_RD_SUM | read +8 into sum
// S_RD_OVF | read +12, bit 0 into overflow
// S_DONE   | done pulse; busy drops on the way back to IDLE

module adder_axi_sequencer #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                    TIMEOUT_CYCLES = 64
) (
   input  logic                    m1_axi_aclk,
   input  logic                    m1_axi_aresetn,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   op_a,
   input  logic [DATA_WIDTH-1:0]   op_b,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   sum,
   output logic                    overflow,
   output logic                    err,
   output logic [2:0]              err_phase,
   output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
   output logic                    m1_axi_awvalid,
   input  logic                    m1_axi_awready,
   output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
   output logic                    m1_axi_wvalid,
   input  logic                    m1_axi_wready,
   input  logic [1:0]              m1_axi_bresp,
   input  logic                    m1_axi_bvalid,
   output logic                    m1_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
   output logic                    m1_axi_arvalid,
   input  logic                    m1_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
   input  logic [1:0]              m1_axi_rresp,
   input  logic                    m1_axi_rvalid,
   output logic                    m1_axi_rready
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

   // Offsets wrap modulo 2^ADDR_WIDTH through truncation.
   localparam logic [ADDR_WIDTH-1:0] ADDR_A   = BASE_ADDR;
   localparam logic [ADDR_WIDTH-1:0] ADDR_B   = BASE_ADDR + ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] ADDR_SUM = BASE_ADDR + ADDR_WIDTH'(8);
   localparam logic [ADDR_WIDTH-1:0] ADDR_OVF = BASE_ADDR + ADDR_WIDTH'(12);

   // Encodings 1..4 double as the err_phase codes.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WR_A   = 3'd1,
      S_WR_B   = 3'd2,
      S_RD_SUM = 3'd3,
      S_RD_OVF = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   b_q;
   logic                    aw_done;
   logic                    w_done;
   logic [TW-1:0]           tmr;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic phase_done, resp_err, abort;

   assign aw_hs = m1_axi_awvalid & m1_axi_awready;
   assign w_hs  = m1_axi_wvalid  & m1_axi_wready;
   assign b_hs  = m1_axi_bvalid  & m1_axi_bready;
   assign ar_hs = m1_axi_arvalid & m1_axi_arready;
   assign r_hs  = m1_axi_rvalid  & m1_axi_rready;

   assign m1_axi_wstrb = '1;

   always_comb begin
      phase_done = 1'b0;
      resp_err   = 1'b0;
      case (state)
         S_WR_A, S_WR_B: begin
            phase_done = b_hs;
            resp_err   = (m1_axi_bresp != 2'b00);
         end
         S_RD_SUM, S_RD_OVF: begin
            phase_done = r_hs;
            resp_err   = (m1_axi_rresp != 2'b00);
         end
         default: ;
      endcase
   end

   // A completing handshake wins over a timer hitting zero on the same edge.
   assign abort = phase_done ? resp_err : (tmr == '0);

   always_ff @(posedge m1_axi_aclk) begin
      if (!m1_axi_aresetn) begin
         state          <= S_IDLE;
         b_q            <= '0;
         aw_done        <= 1'b0;
         w_done         <= 1'b0;
         tmr            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         sum            <= '0;
         overflow       <= 1'b0;
         err            <= 1'b0;
         err_phase      <= 3'd0;
         m1_axi_awaddr  <= '0;
         m1_axi_awvalid <= 1'b0;
         m1_axi_wdata   <= '0;
         m1_axi_wvalid  <= 1'b0;
         m1_axi_bready  <= 1'b0;
         m1_axi_araddr  <= '0;
         m1_axi_arvalid <= 1'b0;
         m1_axi_rready  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  b_q            <= op_b;
                  busy           <= 1'b1;
                  err            <= 1'b0;
                  err_phase      <= 3'd0;
                  m1_axi_awaddr  <= ADDR_A;
                  m1_axi_wdata   <= op_a;
                  m1_axi_awvalid <= 1'b1;
                  m1_axi_wvalid  <= 1'b1;
                  aw_done        <= 1'b0;
                  w_done         <= 1'b0;
                  tmr            <= TMR_LOAD;
                  state          <= S_WR_A;
               end
            end

            S_WR_A, S_WR_B, S_RD_SUM, S_RD_OVF: begin
               if (abort) begin
                  m1_axi_awvalid <= 1'b0;
                  m1_axi_wvalid  <= 1'b0;
                  m1_axi_bready  <= 1'b0;
                  m1_axi_arvalid <= 1'b0;
                  m1_axi_rready  <= 1'b0;
                  err            <= 1'b1;
                  err_phase      <= 3'(state);
                  done           <= 1'b1;
                  state          <= S_DONE;
               end else if (phase_done) begin
                  tmr           <= TMR_LOAD;
                  m1_axi_bready <= 1'b0;
                  m1_axi_rready <= 1'b0;
                  case (state)
                     S_WR_A: begin
                        m1_axi_awaddr  <= ADDR_B;
                        m1_axi_wdata   <= b_q;
                        m1_axi_awvalid <= 1'b1;
                        m1_axi_wvalid  <= 1'b1;
                        aw_done        <= 1'b0;
                        w_done         <= 1'b0;
                        state          <= S_WR_B;
                     end
                     S_WR_B: begin
                        m1_axi_araddr  <= ADDR_SUM;
                        m1_axi_arvalid <= 1'b1;
                        state          <= S_RD_SUM;
                     end
                     S_RD_SUM: begin
                        sum            <= m1_axi_rdata;
                        m1_axi_araddr  <= ADDR_OVF;
                        m1_axi_arvalid <= 1'b1;
                        state          <= S_RD_OVF;
                     end
                     default: begin
                        overflow <= m1_axi_rdata[0];
                        done     <= 1'b1;
                        state    <= S_DONE;
                     end
                  endcase
               end else begin
                  tmr <= tmr - TW'(1);
                  if (state == S_WR_A || state == S_WR_B) begin
                     if (aw_hs) begin
                        m1_axi_awvalid <= 1'b0;
                        aw_done        <= 1'b1;
                     end
                     if (w_hs) begin
                        m1_axi_wvalid <= 1'b0;
                        w_done        <= 1'b1;
                     end
                     // Response is accepted only after both AW and W are through.
                     m1_axi_bready <= (aw_done | aw_hs) & (w_done | w_hs);
                  end else if (ar_hs) begin
                     m1_axi_arvalid <= 1'b0;
                     m1_axi_rready  <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_axi_sequencer.sv
module tb_adder_axi_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        busy, done, overflow, err;
   logic [31:0] sum;
   logic [2:0]  err_phase;
   logic [7:0]  awaddr, araddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, bready, arvalid, rready;

   // slave-driven signals
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [1:0]  bresp = 2'b00, rresp = 2'b00;
   logic [31:0] rdata = '0;

   int vectors = 0;
   int miscompares = 0;

   // slave configuration, written by the main sequence only
   int   aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic rand_stall = 1'b0;
   logic bresp_err_b = 1'b0;
   logic never_ar_sum = 1'b0;

   // slave state and logs, written by the slave process only
   logic [31:0] reg_a = '0, reg_b = '0;
   logic [7:0]  wr_log_addr [64];
   logic [31:0] wr_log_data [64];
   logic [7:0]  rd_log_addr [64];
   int          wr_n = 0, rd_n = 0, stab_err = 0;

   always #5 clk = ~clk;

   adder_axi_sequencer dut (
      .m1_axi_aclk    (clk),
      .m1_axi_aresetn (rst_n),
      .start          (start),
      .op_a           (op_a),
      .op_b           (op_b),
      .busy           (busy),
      .done           (done),
      .sum            (sum),
      .overflow       (overflow),
      .err            (err),
      .err_phase      (err_phase),
      .m1_axi_awaddr  (awaddr),
      .m1_axi_awvalid (awvalid),
      .m1_axi_awready (awready),
      .m1_axi_wdata   (wdata),
      .m1_axi_wstrb   (wstrb),
      .m1_axi_wvalid  (wvalid),
      .m1_axi_wready  (wready),
      .m1_axi_bresp   (bresp),
      .m1_axi_bvalid  (bvalid),
      .m1_axi_bready  (bready),
      .m1_axi_araddr  (araddr),
      .m1_axi_arvalid (arvalid),
      .m1_axi_arready (arready),
      .m1_axi_rdata   (rdata),
      .m1_axi_rresp   (rresp),
      .m1_axi_rvalid  (rvalid),
      .m1_axi_rready  (rready)
   );

   function automatic logic [31:0] rd_val(input logic [7:0] addr);
      logic [32:0] s;
      s = {1'b0, reg_a} + {1'b0, reg_b};
      case (addr)
         8'h08:   rd_val = s[31:0];
         8'h0C:   rd_val = {31'h7FFF_FFFF, s[32]};
         default: rd_val = 32'hDEAD_BEEF;
      endcase
   endfunction

   // Adder slave model. Runs on the falling edge: first it resolves the
   // handshakes of the preceding rising edge from last half-cycle's samples,
   // then it drives ready/valid for the next rising edge.
   initial begin : slave
      logic       p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
      logic [7:0] p_awaddr, p_araddr, aw_a, ar_a;
      logic [31:0] p_wdata, w_d;
      logic       aw_got, w_got, ar_got;
      int         aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
      int         aw_rl, w_rl, b_rl, ar_rl, r_rl;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            bresp = 0; rresp = 0;
            p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
            p_awaddr = 0; p_araddr = 0; p_wdata = 0; aw_a = 0; ar_a = 0; w_d = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_rl = 0; w_rl = 0; b_rl = 0; ar_rl = 0; r_rl = 0;
            continue;
         end
         // stability of pending requests
         if (p_awvalid && !awready && (!awvalid || awaddr != p_awaddr)) stab_err++;
         if (p_wvalid && !wready && (!wvalid || wdata != p_wdata)) stab_err++;
         if (p_arvalid && !arready && (!arvalid || araddr != p_araddr)) stab_err++;
         // handshakes at the preceding rising edge
         if (p_awvalid && awready) begin
            aw_got = 1; aw_a = p_awaddr; aw_cnt = 0; aw_rl = $urandom_range(0, 5);
         end
         if (p_wvalid && wready) begin
            w_got = 1; w_d = p_wdata; w_cnt = 0; w_rl = $urandom_range(0, 5);
         end
         if (bvalid && p_bready) begin
            if (wr_n < 64) begin
               wr_log_addr[wr_n] = aw_a;
               wr_log_data[wr_n] = w_d;
            end
            wr_n++;
            if (bresp == 2'b00) begin
               if (aw_a == 8'h00) reg_a = w_d;
               if (aw_a == 8'h04) reg_b = w_d;
            end
            bvalid = 0; bresp = 0; aw_got = 0; w_got = 0;
            b_cnt = 0; b_rl = $urandom_range(0, 5);
         end
         if (p_arvalid && arready) begin
            ar_got = 1; ar_a = p_araddr; ar_cnt = 0; ar_rl = $urandom_range(0, 5);
            if (rd_n < 64) rd_log_addr[rd_n] = p_araddr;
            rd_n++;
         end
         if (rvalid && p_rready) begin
            rvalid = 0; ar_got = 0; r_cnt = 0; r_rl = $urandom_range(0, 5);
         end
         // drive for the next rising edge
         awready = 0;
         if (awvalid && !aw_got) begin
            if (aw_cnt >= (rand_stall ? aw_rl : aw_dly)) awready = 1;
            else aw_cnt++;
         end
         wready = 0;
         if (wvalid && !w_got) begin
            if (w_cnt >= (rand_stall ? w_rl : w_dly)) wready = 1;
            else w_cnt++;
         end
         if (aw_got && w_got && !bvalid) begin
            if (b_cnt >= (rand_stall ? b_rl : b_dly)) begin
               bvalid = 1;
               bresp = (bresp_err_b && aw_a == 8'h04) ? 2'b10 : 2'b00;
            end else b_cnt++;
         end
         arready = 0;
         if (arvalid && !ar_got && !(never_ar_sum && araddr == 8'h08)) begin
            if (ar_cnt >= (rand_stall ? ar_rl : ar_dly)) arready = 1;
            else ar_cnt++;
         end
         if (ar_got && !rvalid) begin
            if (r_cnt >= (rand_stall ? r_rl : r_dly)) begin
               rvalid = 1; rdata = rd_val(ar_a); rresp = 2'b00;
            end else r_cnt++;
         end
         p_awvalid = awvalid; p_wvalid = wvalid; p_bready = bready;
         p_arvalid = arvalid; p_rready = rready;
         p_awaddr = awaddr; p_araddr = araddr; p_wdata = wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // lat counts falling edges from the one where start is driven to the one
   // where done is seen; a zero-wait operation gives 9.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy1);
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b;
      @(negedge clk);
      start = 1'b0; lat = 1; busy1 = busy;
      while (!done && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin : main
      int   lat, wb, rb, sb;
      logic b1;

      repeat (3) @(negedge clk);
      chk("rst_busy",    32'(busy), 0);
      chk("rst_done",    32'(done), 0);
      chk("rst_err",     32'(err), 0);
      chk("rst_phase",   32'(err_phase), 0);
      chk("rst_sum",     sum, 0);
      chk("rst_ovf",     32'(overflow), 0);
      chk("rst_valids",  32'({awvalid, wvalid, bready, arvalid, rready}), 0);
      chk("rst_addrs",   32'({awaddr, araddr}), 0);
      chk("rst_wdata",   wdata, 0);
      chk("rst_wstrb",   32'(wstrb), 32'hF);
      rst_n = 1'b1;

      // zero-wait, 5 + 7
      wb = wr_n; rb = rd_n; sb = stab_err;
      run_op(32'd5, 32'd7, lat, b1);
      chk("t1_busy_start", 32'(b1), 1);
      chk("t1_latency",    lat, 9);
      chk("t1_done",       32'(done), 1);
      chk("t1_sum",        sum, 32'd12);
      chk("t1_ovf",        32'(overflow), 0);
      chk("t1_err",        32'({err, err_phase}), 0);
      @(negedge clk);
      chk("t1_busy_end",   32'({busy, done}), 0);
      chk("t1_wr_a",       {16'h0, wr_log_addr[wb], 8'(wr_log_data[wb])}, 32'h0000_0005);
      chk("t1_wr_b",       {16'h0, wr_log_addr[wb+1], 8'(wr_log_data[wb+1])}, 32'h0000_0407);
      chk("t1_rd_addrs",   32'({rd_log_addr[rb], rd_log_addr[rb+1]}), 32'h080C);
      chk("t1_counts",     32'((wr_n - wb) * 16 + (rd_n - rb)), 32'h22);

      // all-ones + 1 wraps and sets overflow
      run_op(32'hFFFF_FFFF, 32'd1, lat, b1);
      chk("t2_latency", lat, 9);
      chk("t2_sum",     sum, 32'd0);
      chk("t2_ovf",     32'(overflow), 1);
      chk("t2_err",     32'(err), 0);

      // wready leads awready by 3 cycles on each write
      aw_dly = 3;
      sb = stab_err;
      run_op(32'h1234_5678, 32'h1111_1111, lat, b1);
      chk("t3_latency", lat, 15);
      chk("t3_sum",     sum, 32'h2345_6789);
      chk("t3_ovf",     32'(overflow), 0);
      chk("t3_err",     32'(err), 0);
      @(negedge clk);
      chk("t3_stable",  stab_err - sb, 0);
      aw_dly = 0;

      // random 0-5 cycle stalls on every channel
      rand_stall = 1'b1;
      sb = stab_err;
      run_op(32'h8000_0000, 32'h8000_0001, lat, b1);
      chk("t4a_sum", sum, 32'd1);
      chk("t4a_ovf", 32'(overflow), 1);
      chk("t4a_err", 32'(err), 0);
      wb = wr_n;
      run_op(32'd100, 32'd200, lat, b1);
      chk("t4b_sum", sum, 32'd300);
      chk("t4b_ovf", 32'(overflow), 0);
      chk("t4b_err", 32'(err), 0);
      @(negedge clk);
      chk("t4_stable", stab_err - sb, 0);
      chk("t4b_wr_a",  {wr_log_data[wb][15:0], 8'h0, wr_log_addr[wb]}, 32'h0064_0000);
      chk("t4b_wr_b",  {wr_log_data[wb+1][15:0], 8'h0, wr_log_addr[wb+1]}, 32'h00C8_0004);
      rand_stall = 1'b0;

      // SLVERR on the write to +4
      bresp_err_b = 1'b1;
      rb = rd_n;
      run_op(32'd3, 32'd4, lat, b1);
      chk("t5_latency", lat, 5);
      chk("t5_err",     32'(err), 1);
      chk("t5_phase",   32'(err_phase), 2);
      chk("t5_sum",     sum, 32'd300);
      @(negedge clk);
      chk("t5_no_reads", rd_n - rb, 0);
      chk("t5_idle",    32'({busy, awvalid, wvalid, bready, arvalid}), 0);
      bresp_err_b = 1'b0;

      // arready never comes for the sum read
      never_ar_sum = 1'b1;
      rb = rd_n;
      run_op(32'd9, 32'd10, lat, b1);
      chk("t6_latency", lat, 69);
      chk("t6_err",     32'(err), 1);
      chk("t6_phase",   32'(err_phase), 3);
      chk("t6_arvalid", 32'({arvalid, rready}), 0);
      chk("t6_sum",     sum, 32'd300);
      chk("t6_no_reads", rd_n - rb, 0);
      never_ar_sum = 1'b0;
      run_op(32'd20, 32'd22, lat, b1);
      chk("t6b_latency", lat, 9);
      chk("t6b_sum",     sum, 32'd42);
      chk("t6b_err",     32'({err, err_phase}), 0);

      // reset while waiting for the sum read data
      r_dly = 10;
      @(negedge clk);
      start = 1'b1; op_a = 32'd1; op_b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!rready && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("t7_rready_seen", 32'({rready, busy}), 32'h3);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t7_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 0);
      chk("t7_flags",  32'({busy, done, err, err_phase, overflow}), 0);
      chk("t7_sum",    sum, 0);
      chk("t7_bus",    32'({awaddr, araddr, wdata[15:0]}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      r_dly = 0;

      // second start while busy is ignored
      wb = wr_n; rb = rd_n;
      @(negedge clk);
      start = 1'b1; op_a = 32'd6; op_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; op_a = 32'd100; op_b = 32'd100;
      @(negedge clk);
      start = 1'b0;
      lat = 3;
      while (!done && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      chk("t8_latency", lat, 9);
      chk("t8_sum",     sum, 32'd13);
      chk("t8_err",     32'(err), 0);
      repeat (6) @(negedge clk);
      chk("t8_idle",    32'(busy), 0);
      chk("t8_counts",  32'((wr_n - wb) * 16 + (rd_n - rb)), 32'h22);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
